// File: rtl/h14tx_timings_decoder.sv
// h14tx_timings_decoder
// Turns the raster cursor (x, y) into registered HDMI 1.4 transmitter timing
// controls: hsync, vsync, data enable, preamble CTL bits and the leading video
// guard band. A four-state period FSM makes sure a video data period is only
// entered after a complete 8-pixel preamble followed by a 2-pixel guard band.
// Every output reflects the cursor position sampled on the previous clk edge.
module h14tx_timings_decoder #(
  parameter int   BitWidth  = 11,
  parameter int   BitHeight = 10,
  parameter int   Width     = 1650,
  parameter int   Height    = 750,
  parameter int   HActive   = 1280,
  parameter int   HFront    = 110,
  parameter int   HSync     = 40,
  parameter int   VActive   = 720,
  parameter int   VFront    = 5,
  parameter int   VSync     = 5,
  parameter logic HPolarity = 1'b1,
  parameter logic VPolarity = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BitWidth-1:0]  x,
  input  logic [BitHeight-1:0] y,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic                 guard,
  output logic [3:0]           ctl,
  output logic                 frame_start
);

  // All position arithmetic is done on 32-bit unsigned values so that y+1
  // and the window bounds never wrap.
  localparam logic [31:0] W_L       = 32'(Width);
  localparam logic [31:0] H_L       = 32'(Height);
  localparam logic [31:0] H_LAST    = 32'(Height - 1);
  localparam logic [31:0] HA_L      = 32'(HActive);
  localparam logic [31:0] VA_L      = 32'(VActive);
  localparam logic [31:0] PRE_FIRST = 32'(Width - 10);
  localparam logic [31:0] PRE_LAST  = 32'(Width - 3);
  localparam logic [31:0] GRD_FIRST = 32'(Width - 2);
  localparam logic [31:0] GRD_LAST  = 32'(Width - 1);
  localparam logic [31:0] HS_START  = 32'(HActive + HFront);
  localparam logic [31:0] HS_END    = 32'(HActive + HFront + HSync);
  localparam logic [31:0] VS_START  = 32'(VActive + VFront);
  localparam logic [31:0] VS_END    = 32'(VActive + VFront + VSync);

  typedef enum logic [1:0] {
    ST_CTRL  = 2'd0,
    ST_PRE   = 2'd1,
    ST_GUARD = 2'd2,
    ST_VIDEO = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        de_q, de_d;
  logic        guard_q, guard_d;
  logic [3:0]  ctl_q, ctl_d;
  logic        fs_q, fs_d;

  logic [31:0] x_ext_s;
  logic [31:0] y_ext_s;
  logic        in_range_s;
  logic        next_act_s;
  logic        hsync_act_s;
  logic        vsync_act_s;

  assign x_ext_s = 32'(x);
  assign y_ext_s = 32'(y);

  // Position decode: range check, next-line-active flag and sync windows.
  always_comb begin
    in_range_s  = (x_ext_s < W_L) && (y_ext_s < H_L);
    if (y_ext_s == H_LAST) begin
      // Line 0 of the next frame is always active.
      next_act_s = 1'b1;
    end else begin
      next_act_s = ((y_ext_s + 32'd1) < VA_L);
    end
    hsync_act_s = in_range_s && (x_ext_s >= HS_START) && (x_ext_s < HS_END);
    vsync_act_s = in_range_s && (y_ext_s >= VS_START) && (y_ext_s < VS_END);
  end

  // Period FSM next state. The state names the period of the pixel just
  // sampled, so VIDEO can only be reached through PRE and GUARD.
  always_comb begin
    state_d = state_q;
    if (!in_range_s) begin
      state_d = ST_CTRL;
    end else begin
      case (state_q)
        ST_CTRL: begin
          if ((x_ext_s == PRE_FIRST) && next_act_s) begin
            state_d = ST_PRE;
          end else begin
            state_d = ST_CTRL;
          end
        end
        ST_PRE: begin
          if (!next_act_s) begin
            state_d = ST_CTRL;
          end else if (x_ext_s == GRD_FIRST) begin
            state_d = ST_GUARD;
          end else if ((x_ext_s > PRE_FIRST) && (x_ext_s <= PRE_LAST)) begin
            state_d = ST_PRE;
          end else begin
            state_d = ST_CTRL;
          end
        end
        ST_GUARD: begin
          if ((x_ext_s == GRD_LAST) && next_act_s) begin
            state_d = ST_GUARD;
          end else if ((x_ext_s == 32'd0) && (y_ext_s < VA_L)) begin
            // Guard band ends at the line wrap; the new line is active.
            state_d = ST_VIDEO;
          end else begin
            state_d = ST_CTRL;
          end
        end
        ST_VIDEO: begin
          if ((x_ext_s < HA_L) && (y_ext_s < VA_L)) begin
            state_d = ST_VIDEO;
          end else begin
            state_d = ST_CTRL;
          end
        end
        default: begin
          state_d = ST_CTRL;
        end
      endcase
    end
  end

  // Output next values: period controls from the entered state, syncs and
  // frame marker straight from the position decode.
  always_comb begin
    de_d    = 1'b0;
    guard_d = 1'b0;
    ctl_d   = 4'b0000;
    case (state_d)
      ST_PRE: begin
        ctl_d = 4'b0001;
      end
      ST_GUARD: begin
        guard_d = 1'b1;
      end
      ST_VIDEO: begin
        de_d = 1'b1;
      end
      default: begin
        de_d    = 1'b0;
        guard_d = 1'b0;
        ctl_d   = 4'b0000;
      end
    endcase
    if (hsync_act_s) begin
      hsync_d = HPolarity;
    end else begin
      hsync_d = ~HPolarity;
    end
    if (vsync_act_s) begin
      vsync_d = VPolarity;
    end else begin
      vsync_d = ~VPolarity;
    end
    fs_d = (x_ext_s == 32'd0) && (y_ext_s == 32'd0);
  end

  // State and output registers; reset drives syncs to their inactive level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CTRL;
      hsync_q <= ~HPolarity;
      vsync_q <= ~VPolarity;
      de_q    <= 1'b0;
      guard_q <= 1'b0;
      ctl_q   <= 4'b0000;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      guard_q <= guard_d;
      ctl_q   <= ctl_d;
      fs_q    <= fs_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign guard       = guard_q;
  assign ctl         = ctl_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_h14tx_timings_decoder.sv
// Scoreboard bench for h14tx_timings_decoder on a reduced raster so several
// whole frames fit in a short run. Two instances share the cursor: one with
// active-high syncs and one with active-low syncs.
module tb_h14tx_timings_decoder;

  localparam int W  = 40;
  localparam int H  = 12;
  localparam int HA = 20;
  localparam int HF = 4;
  localparam int HS = 4;
  localparam int VA = 6;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int FRAME  = W * H;
  localparam int NCYC   = 5 * FRAME;
  localparam int RST_T  = 3 * FRAME + 2 * W + 10;
  localparam int FRC_T0 = 4 * FRAME;

  // {hsync, vsync, de, guard, ctl[3:0], frame_start, hsync_n, vsync_n}
  localparam logic [10:0] RST_V = 11'b000_0000_0011;

  typedef struct {
    logic [10:0] v;
    int          t;
    int          px;
    int          py;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [5:0] x;
  logic [3:0] y;
  logic       hsync, vsync, de, guard, frame_start;
  logic [3:0] ctl;
  logic       hsync_n, vsync_n, de_n, guard_n, frame_start_n;
  logic [3:0] ctl_n;
  logic [10:0] outv;

  int   n_checks;
  int   n_errors;
  int   m_phase;
  exp_t q[$];

  h14tx_timings_decoder #(
    .BitWidth(6), .BitHeight(4), .Width(W), .Height(H), .HActive(HA),
    .HFront(HF), .HSync(HS), .VActive(VA), .VFront(VF), .VSync(VS),
    .HPolarity(1'b1), .VPolarity(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .hsync(hsync), .vsync(vsync),
    .de(de), .guard(guard), .ctl(ctl), .frame_start(frame_start)
  );

  h14tx_timings_decoder #(
    .BitWidth(6), .BitHeight(4), .Width(W), .Height(H), .HActive(HA),
    .HFront(HF), .HSync(HS), .VActive(VA), .VFront(VF), .VSync(VS),
    .HPolarity(1'b0), .VPolarity(1'b0)
  ) dut_n (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .hsync(hsync_n), .vsync(vsync_n),
    .de(de_n), .guard(guard_n), .ctl(ctl_n), .frame_start(frame_start_n)
  );

  assign outv = {hsync, vsync, de, guard, ctl, frame_start, hsync_n, vsync_n};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: expected outputs one cycle after (xi, yi) is sampled.
  task automatic model_step(input int xi, input int yi, output logic [10:0] e);
    bit inr, na, hact, vact;
    int ph;
    inr  = (xi < W) && (yi < H);
    na   = (yi == H - 1) ? 1'b1 : ((yi + 1) < VA);
    hact = inr && (xi >= HA + HF) && (xi < HA + HF + HS);
    vact = inr && (yi >= VA + VF) && (yi < VA + VF + VS);
    ph   = 0;
    if (inr) begin
      case (m_phase)
        0: ph = (xi == W - 10 && na) ? 1 : 0;
        1: ph = (na && xi >= W - 9 && xi <= W - 3) ? 1 : ((na && xi == W - 2) ? 2 : 0);
        2: ph = (na && xi == W - 1) ? 2 : ((xi == 0 && yi < VA) ? 3 : 0);
        3: ph = (xi < HA && yi < VA) ? 3 : 0;
        default: ph = 0;
      endcase
    end
    m_phase = ph;
    e = {hact, vact, (ph == 3), (ph == 2), 3'b000, (ph == 1),
         (inr && xi == 0 && yi == 0), ~hact, ~vact};
  endtask

  initial begin
    exp_t        ent;
    logic [10:0] ev;
    int cx, cy, dx, dy;
    int de_f1, pre_last_f1, grd_last_f1, pre_lastact_f1, fs_cnt;
    int first_de_x, first_de_y;
    bit after_rst;

    n_checks = 0; n_errors = 0; m_phase = 0;
    de_f1 = 0; pre_last_f1 = 0; grd_last_f1 = 0; pre_lastact_f1 = 0; fs_cnt = 0;
    first_de_x = -1; first_de_y = -1; after_rst = 1'b0;
    rst_n = 1'b0; x = 6'd0; y = 4'd0;

    repeat (3) @(negedge clk);
    chk("reset_state", 32'(outv), 32'(RST_V));

    for (int t = 0; t < NCYC + 1; t++) begin
      @(negedge clk);
      if (q.size() > 0) begin
        ent = q.pop_front();
        chk("outputs", 32'(outv), 32'(ent.v));
        chk("exclusive", 32'(((32'(de) + 32'(guard) + 32'(|ctl)) <= 32'd1)), 32'd1);
        if (ent.t / FRAME == 1) begin
          if (de) de_f1++;
          if (ent.py == H - 1 && ctl == 4'b0001) pre_last_f1++;
          if (ent.py == H - 1 && guard) grd_last_f1++;
          if (ent.py == VA - 1 && (ctl != 4'b0000 || guard)) pre_lastact_f1++;
        end
        if (ent.t < 3 * FRAME && frame_start) fs_cnt++;
        if (after_rst && de && first_de_y < 0) begin
          first_de_x = ent.px;
          first_de_y = ent.py;
        end
      end
      if (t == NCYC) break;

      // Reset control: release at t=0, then a short pulse mid active line.
      if (t == 0) begin
        rst_n = 1'b1;
      end
      if (t == RST_T) begin
        rst_n = 1'b0;
        #1;
        chk("rst_async", 32'(outv), 32'(RST_V));
        q.delete();
        m_phase = 0;
        after_rst = 1'b1;
      end else if (t > RST_T && t <= RST_T + 3) begin
        chk("rst_hold", 32'(outv), 32'(RST_V));
        if (t == RST_T + 3) rst_n = 1'b1;
      end

      // Free-running cursor, with a few out-of-range overrides in frame 4.
      cx = t % W;
      cy = (t / W) % H;
      dx = cx;
      dy = cy;
      if (t == FRC_T0 + 1 * W + 5)  dx = 45;
      if (t == FRC_T0 + 2 * W + 33) dx = 45;
      if (t == FRC_T0 + 4 * W + 15) dy = 13;
      x = 6'(dx);
      y = 4'(dy);
      if (rst_n) begin
        model_step(dx, dy, ev);
        ent.v = ev; ent.t = t; ent.px = dx; ent.py = dy;
        q.push_back(ent);
      end
    end

    chk("de_per_frame", 32'(de_f1), 32'(VA * HA));
    chk("pre_last_line", 32'(pre_last_f1), 32'd8);
    chk("guard_last_line", 32'(grd_last_f1), 32'd2);
    chk("no_pre_last_active", 32'(pre_lastact_f1), 32'd0);
    chk("frame_start_count", 32'(fs_cnt), 32'd3);
    chk("de_resume_y", 32'(first_de_y), 32'd3);
    chk("de_resume_x", 32'(first_de_x), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
